gameover_overlay_ctrl: RTL and testbench
========================================

// Module: gameover_overlay_ctrl
// PURPOSE
//  Upstream driver of the game-over banner renderer: takes VGA scan coords, runs the banner
//  slide-in/blink animation per frame, emits banner-relative X/Y (ROM address source) and a
//  window-active flag delayed to line up with the renderer's registered colour output.
//  Feeds the renderer's RelativeXG/RelativeYG; the overlay flag drives the top-level colour mux.
// PARAMETERS
//  IMG_W        240  banner width (px); must equal renderer ROM row stride
//  IMG_H        68   banner height (px); IMG_W*IMG_H <= 16384
//  WIN_X        200  banner left edge, fixed
//  TARGET_Y     206  final banner top row
//  SLIDE_STEP   4    rows per frame banner descends during slide
//  BLINK_FRAMES 30   frames per visible/hidden half-period in HOLD
//  SCREEN_H     480  first vblank line (frame tick row)
//  ALIGN_DLY    2    extra cycles on overlay_active (ROM read + renderer output register)
// PORTS
//  vga_clk        in   1   pixel clock, sole clock
//  reset          in   1   asynchronous, active-high
//  DrawX          in   10  current scan X
//  DrawY          in   10  current scan Y
//  game_over      in   1   level; high = game has ended
//  restart        in   1   one-cycle pulse; returns to IDLE
//  RelativeXG     out  10  DrawX-WIN_X inside window, else 0 (registered)
//  RelativeYG     out  10  DrawY-banner_top inside window, else 0 (registered)
//  overlay_active out  1   pixel is banner and visible, aligned to renderer colour output
//  anim_done      out  1   high in HOLD
// BEHAVIOUR
//  Reset (async): state=IDLE, banner_top=0, blink_cnt=0, visible=0, all outputs 0, delay line 0.
//  frame_tick: internal 1-cycle strobe when DrawX==0 && DrawY==SCREEN_H; all animation state
//   updates only on frame_tick (vblank) -> no mid-frame tearing.
//  FSM (advances on frame_tick except restart):
//   IDLE  : visible=0. game_over high at tick -> SLIDE, banner_top=0, visible=1.
//   SLIDE : banner_top += SLIDE_STEP; if result >= TARGET_Y clamp to TARGET_Y, -> HOLD, blink_cnt=0.
//   HOLD  : blink_cnt++; at BLINK_FRAMES-1 wrap to 0 and toggle visible. anim_done=1.
//   restart pulse, any state, any cycle (has priority over frame_tick) -> IDLE next cycle,
//   banner_top=0, visible=0. game_over low at tick in SLIDE/HOLD -> IDLE.
//  Window: in_win = DrawX in [WIN_X, WIN_X+IMG_W-1] && DrawY in [banner_top, banner_top+IMG_H-1];
//   compare in 11 bits, no wrap; rows beyond 479 never occur on scan so clipping is implicit.
//  Stage 1 (1 cycle after DrawX/DrawY): RelativeXG/YG registered; outside window both 0 so ROM
//   address stays in range. active_s1 = in_win && visible && state!=IDLE.
//  overlay_active = active_s1 delayed ALIGN_DLY more cycles (total 1+ALIGN_DLY from scan coords).
//  Delay line is not flushed on restart; it drains naturally (<=3 cycles).
//  game_over rising mid-frame: no visible effect until next frame_tick.
// STRUCTURE
//  Shared package gameover_pkg: typedef enum logic[1:0] {GO_IDLE,GO_SLIDE,GO_HOLD} go_state_t;
//   IMG_W/IMG_H constants, also used by the renderer.
//  Sub-module: gameover_delay_line (parameterised DEPTH x WIDTH shift register, async reset)
//   for overlay_active alignment.
// TESTING
//  1 reset mid-HOLD -> all outputs 0 same cycle; state IDLE after release.
//  2 game_over=1, run frames -> banner_top 0,4,...,204 then clamp 206 on frame 52; anim_done=1.
//  3 HOLD: overlay_active at (200,206) high 30 frames, low next 30, high again.
//  4 DrawX=200,DrawY=206 in HOLD visible -> RelativeXG/YG=0/0 after 1 cycle, overlay_active after 3;
//    DrawX=439,DrawY=273 -> 239/67; DrawX=440 -> 0/0, overlay 0.
//  5 restart coincident with frame_tick in SLIDE -> IDLE, banner_top=0; no SLIDE step applied.
//  6 game_over dropped during SLIDE -> IDLE at next frame_tick, overlay_active 0 thereafter.

Source files
------------

// File: rtl/gameover_pkg.sv
// Shared definitions for the game-over banner: animation states and banner geometry.
// IMG_W/IMG_H are also used by the banner renderer to size its ROM.
package gameover_pkg;

    typedef enum logic [1:0] {GO_IDLE, GO_SLIDE, GO_HOLD} go_state_t;

    localparam int IMG_W        = 240;
    localparam int IMG_H        = 68;
    localparam int WIN_X        = 200;
    localparam int TARGET_Y     = 206;
    localparam int SLIDE_STEP   = 4;
    localparam int BLINK_FRAMES = 30;
    localparam int SCREEN_H     = 480;
    localparam int ALIGN_DLY    = 2;

endpackage

// File: rtl/gameover_delay_line.sv
// DEPTH-stage shift register of WIDTH-bit words with asynchronous active-high reset.
// Used to align the overlay flag with the renderer's registered colour output.
module gameover_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/gameover_overlay_ctrl.sv
// Game-over banner driver: per-frame slide-in/blink animation, banner-relative ROM
// coordinates and an overlay flag aligned with the renderer's colour output.
module gameover_overlay_ctrl
    import gameover_pkg::*;
(
    input  logic       vga_clk,
    input  logic       reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       game_over,
    input  logic       restart,
    output logic [9:0] RelativeXG,
    output logic [9:0] RelativeYG,
    output logic       overlay_active,
    output logic       anim_done
);

    localparam int BW = $clog2(BLINK_FRAMES);

    go_state_t     state_q, state_d;
    logic [9:0]    banner_top_q, banner_top_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          visible_q, visible_d;
    logic          anim_done_q, anim_done_d;
    logic [9:0]    rel_x_q, rel_x_d;
    logic [9:0]    rel_y_q, rel_y_d;
    logic          active_s1_q, active_s1_d;

    logic          frame_tick;
    logic          in_win;
    logic [10:0]   x_ext, y_ext, top_ext, top_step;

    // Animation only moves at the first vblank pixel so a frame never shows two banner positions.
    assign frame_tick = (DrawX == 10'd0) && (DrawY == 10'(SCREEN_H));

    assign x_ext    = {1'b0, DrawX};
    assign y_ext    = {1'b0, DrawY};
    assign top_ext  = {1'b0, banner_top_q};
    assign top_step = top_ext + 11'(SLIDE_STEP);

    always_comb begin
        state_d      = state_q;
        banner_top_d = banner_top_q;
        blink_cnt_d  = blink_cnt_q;
        visible_d    = visible_q;
        if (restart) begin
            state_d      = GO_IDLE;
            banner_top_d = '0;
            blink_cnt_d  = '0;
            visible_d    = 1'b0;
        end else if (frame_tick) begin
            case (state_q)
                GO_IDLE: begin
                    visible_d = 1'b0;
                    if (game_over) begin
                        state_d      = GO_SLIDE;
                        banner_top_d = '0;
                        visible_d    = 1'b1;
                    end
                end
                GO_SLIDE, GO_HOLD: begin
                    if (!game_over) begin
                        state_d      = GO_IDLE;
                        banner_top_d = '0;
                        blink_cnt_d  = '0;
                        visible_d    = 1'b0;
                    end else if (state_q == GO_SLIDE) begin
                        if (top_step >= 11'(TARGET_Y)) begin
                            banner_top_d = 10'(TARGET_Y);
                            state_d      = GO_HOLD;
                            blink_cnt_d  = '0;
                        end else begin
                            banner_top_d = top_step[9:0];
                        end
                    end else if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                        blink_cnt_d = '0;
                        visible_d   = ~visible_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
                default: state_d = GO_IDLE;
            endcase
        end
        anim_done_d = (state_d == GO_HOLD);
    end

    // Outside the window the relative coords are forced to 0 so the ROM address stays in range.
    always_comb begin
        in_win = (x_ext >= 11'(WIN_X)) && (x_ext <= 11'(WIN_X + IMG_W - 1)) &&
                 (y_ext >= top_ext) && (y_ext <= top_ext + 11'(IMG_H - 1));
        rel_x_d     = in_win ? (DrawX - 10'(WIN_X)) : '0;
        rel_y_d     = in_win ? (DrawY - banner_top_q) : '0;
        active_s1_d = in_win && visible_q && (state_q != GO_IDLE);
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state_q      <= GO_IDLE;
            banner_top_q <= '0;
            blink_cnt_q  <= '0;
            visible_q    <= 1'b0;
            anim_done_q  <= 1'b0;
            rel_x_q      <= '0;
            rel_y_q      <= '0;
            active_s1_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            banner_top_q <= banner_top_d;
            blink_cnt_q  <= blink_cnt_d;
            visible_q    <= visible_d;
            anim_done_q  <= anim_done_d;
            rel_x_q      <= rel_x_d;
            rel_y_q      <= rel_y_d;
            active_s1_q  <= active_s1_d;
        end
    end

    gameover_delay_line #(
        .DEPTH (ALIGN_DLY),
        .WIDTH (1)
    ) u_align (
        .clk  (vga_clk),
        .rst  (reset),
        .din  (active_s1_q),
        .dout (overlay_active)
    );

    assign RelativeXG = rel_x_q;
    assign RelativeYG = rel_y_q;
    assign anim_done  = anim_done_q;

endmodule

// File: tb/tb_gameover_overlay_ctrl.sv
// Self-checking bench for gameover_overlay_ctrl: directed scenarios plus randomized frames,
// compared against a closed-form model of the banner animation (frames since game over).
module tb_gameover_overlay_ctrl;

    logic       vga_clk;
    logic       reset;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       game_over;
    logic       restart;
    logic [9:0] RelativeXG;
    logic [9:0] RelativeYG;
    logic       overlay_active;
    logic       anim_done;

    int checks = 0;
    int errors = 0;

    // Frames elapsed since the animation started; -1 means idle.
    int m_f = -1;

    gameover_overlay_ctrl dut (
        .vga_clk        (vga_clk),
        .reset          (reset),
        .DrawX          (DrawX),
        .DrawY          (DrawY),
        .game_over      (game_over),
        .restart        (restart),
        .RelativeXG     (RelativeXG),
        .RelativeYG     (RelativeYG),
        .overlay_active (overlay_active),
        .anim_done      (anim_done)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    function automatic int modelTop();
        if (m_f < 0) return 0;
        return (4 * m_f >= 206) ? 206 : 4 * m_f;
    endfunction

    function automatic bit modelVisible();
        if (m_f < 0) return 1'b0;
        if (m_f < 52) return 1'b1;
        return (((m_f - 52) / 30) % 2) == 0;
    endfunction

    function automatic bit modelInWin(input int x, input int y);
        int top;
        top = modelTop();
        return (x >= 200) && (x <= 439) && (y >= top) && (y <= top + 67);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic applyStimulus(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
    endtask

    // One vblank frame tick, optionally with a coincident restart pulse.
    task automatic doTick(input bit go, input bit rs);
        game_over = go;
        restart   = rs;
        applyStimulus(0, 480);
        step();
        restart = 1'b0;
        applyStimulus(0, 479);
        if (rs)           m_f = -1;
        else if (m_f < 0) m_f = go ? 0 : -1;
        else if (!go)     m_f = -1;
        else              m_f++;
        checkOutput("anim_done_tick", anim_done, m_f >= 52);
    endtask

    task automatic doRestartMid();
        restart = 1'b1;
        applyStimulus(5, 479);
        step();
        restart = 1'b0;
        applyStimulus(0, 479);
        m_f = -1;
        checkOutput("anim_done_restart", anim_done, 0);
    endtask

    // Single pixel surrounded by off-window filler, checks both pipeline latencies.
    task automatic probe(input int x, input int y);
        bit inw, ov;
        int ex, ey;
        applyStimulus(0, 479);
        step(); step(); step();
        inw = modelInWin(x, y);
        ex  = inw ? x - 200 : 0;
        ey  = inw ? y - modelTop() : 0;
        ov  = inw && modelVisible();
        applyStimulus(x, y);
        step();
        applyStimulus(0, 479);
        checkOutput("rel_x", RelativeXG, ex);
        checkOutput("rel_y", RelativeYG, ey);
        checkOutput("overlay_early1", overlay_active, 0);
        step();
        checkOutput("rel_x_drain", RelativeXG, 0);
        checkOutput("overlay_early2", overlay_active, 0);
        step();
        checkOutput("overlay_aligned", overlay_active, ov);
        step();
        checkOutput("overlay_late", overlay_active, 0);
    endtask

    initial begin
        reset     = 1'b1;
        DrawX     = 10'd0;
        DrawY     = 10'd479;
        game_over = 1'b0;
        restart   = 1'b0;
        step(); step();
        checkOutput("reset_rel_x", RelativeXG, 0);
        checkOutput("reset_rel_y", RelativeYG, 0);
        checkOutput("reset_overlay", overlay_active, 0);
        checkOutput("reset_anim_done", anim_done, 0);
        reset = 1'b0;
        step();

        // Idle: no tick with game_over low starts anything; window sits at rows 0..67.
        doTick(0, 0);
        probe(210, 5);

        // Slide-in to the clamp at 206, probing the banner's top edge each frame.
        for (int i = 0; i < 53; i++) begin
            doTick(1, 0);
            probe(200, modelTop());
            if (modelTop() > 0) probe(200, modelTop() - 1);
        end

        // Geometry corners while held and visible.
        probe(200, 206);
        probe(439, 273);
        probe(440, 206);
        probe(199, 206);
        probe(200, 274);
        probe(200, 205);

        // Blink: 30 frames visible, 30 hidden, visible again.
        for (int i = 0; i < 62; i++) begin
            doTick(1, 0);
            probe(200, 206);
        end

        // Asynchronous reset in HOLD clears outputs immediately.
        applyStimulus(300, 230);
        step(); step(); step();
        checkOutput("pre_reset_rel_x", RelativeXG, 100);
        checkOutput("pre_reset_rel_y", RelativeYG, 24);
        checkOutput("pre_reset_overlay", overlay_active, modelVisible());
        checkOutput("pre_reset_anim_done", anim_done, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_rel_x", RelativeXG, 0);
        checkOutput("async_rel_y", RelativeYG, 0);
        checkOutput("async_overlay", overlay_active, 0);
        checkOutput("async_anim_done", anim_done, 0);
        step();
        reset = 1'b0;
        m_f = -1;
        probe(210, 5);
        doTick(0, 0);
        probe(200, 0);

        // Restart coincident with a frame tick during slide: no step applied.
        for (int i = 0; i < 5; i++) doTick(1, 0);
        probe(200, modelTop());
        doTick(1, 1);
        probe(210, 5);
        probe(200, 20);
        doTick(1, 0);
        probe(200, 0);

        // game_over dropped during slide returns to idle at the next tick.
        for (int i = 0; i < 4; i++) doTick(1, 0);
        game_over = 1'b0;
        probe(200, modelTop());
        doTick(0, 0);
        probe(200, 0);
        probe(250, 30);
        doTick(0, 0);
        probe(250, 30);

        // Randomized frames.
        for (int f = 0; f < 150; f++) begin
            bit go;
            go = ($urandom_range(0, 39) != 0);
            doTick(go, $urandom_range(0, 24) == 0);
            if ($urandom_range(0, 24) == 0) doRestartMid();
            for (int p = 0; p < 2; p++) begin
                int x, y;
                x = $urandom_range(190, 450);
                y = modelTop() + $urandom_range(0, 74) - 3;
                if (y < 0) y = 0;
                if (y > 479) y = 479;
                probe(x, y);
            end
        end

        $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
